// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and the writeback request record.
// Imported by the writeback arbiter and its bench.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execution units and the register-file write port.
// Optional REGARB_SCOREBOARD_EN adds the reservation inputs and the busy vector.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      RegWrite;
  logic [ADDR_W-1:0]         WriteRegister;
  logic [DATA_W-1:0]         WriteData;
  logic [ID_W-1:0]           grant_id;
`ifdef REGARB_SCOREBOARD_EN
  logic                      rsv_valid;
  logic [ADDR_W-1:0]         rsv_addr;
  logic [(2**ADDR_W)-1:0]    busy;

  modport slave (
    input  req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    output req_ready, RegWrite, WriteRegister, WriteData, grant_id, busy
  );
  modport master (
    output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    input  req_ready, RegWrite, WriteRegister, WriteData, grant_id, busy
  );
`else
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, RegWrite, WriteRegister, WriteData, grant_id
  );
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, RegWrite, WriteRegister, WriteData, grant_id
  );
`endif
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin priority picker: first valid at or above rr_ptr (modulo N) wins.
// Purely combinational; the caller owns the pointer.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);
  logic [IDX_W-1:0] cand_idx [N];
  logic [N-1:0]     cand_vld;

  // Candidate gi is the requester gi places after the pointer, wrapped at N.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : IDX_W'(sum);
      assign cand_vld[gi] = valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        grant_idx = cand_idx[k];
        any_grant = 1'b1;
      end
    end
    grant = any_grant ? (N'(1) << grant_idx) : '0;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin share of the register-file write port, 1-cycle latency.
// Define REGARB_SCOREBOARD_EN to add the per-register busy scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic               we_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [ID_W-1:0]    gid_reg;

  logic [NUM_REQ-1:0] arb_valid, arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Requests are invisible during reset so nothing is accepted on that edge.
  assign arb_valid = bus.req_valid & {NUM_REQ{~reset}};

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_rr (
    .valid     (arb_valid),
    .rr_ptr    (rr_ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign bus.req_ready = arb_grant;
  assign sel_addr      = bus.req_addr[arb_idx*ADDR_W +: ADDR_W];
  assign sel_data      = bus.req_data[arb_idx*DATA_W +: DATA_W];

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (arb_any) begin
      rr_ptr_next = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      data_reg   <= '0;
      gid_reg    <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      // Writes to register 0 complete the handshake but never enable the port.
      we_reg     <= arb_any && (sel_addr != ADDR_W'(REG_ZERO));
      if (arb_any) begin
        addr_reg <= sel_addr;
        data_reg <= sel_data;
        gid_reg  <= arb_idx;
      end
    end
  end

  assign bus.RegWrite      = we_reg;
  assign bus.WriteRegister = addr_reg;
  assign bus.WriteData     = data_reg;
  assign bus.grant_id      = gid_reg;

`ifdef REGARB_SCOREBOARD_EN
  localparam int NREG = 2 ** ADDR_W;
  logic [NREG-1:0] busy_reg, busy_next;

  // A reservation landing on the same edge as the retiring write keeps the register busy.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == REG_ZERO) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] =
            (bus.rsv_valid && bus.rsv_addr == ADDR_W'(gi)) ? 1'b1 :
            (we_reg && addr_reg == ADDR_W'(gi))            ? 1'b0 :
                                                             busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  assign bus.busy = busy_reg;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios, then randomized traffic
// against a transaction-level model. Exercises REGARB_SCOREBOARD_EN when defined.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N  = 3;
  localparam int AW = REG_ADDR_W;
  localparam int DW = REG_DATA_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Pending request per requester, held until the model sees it accepted.
  logic    p_vld [N];
  wb_req_t p_req [N];

  // Model state.
  int           m_ptr;
  logic         exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  int           exp_gid;
  logic [REG_COUNT-1:0] m_busy;
  logic         rsv_v;
  logic [AW-1:0] rsv_a;
  int           last_g;
  logic [N-1:0] last_ready;
  logic         cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
  endtask

  task automatic pend(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_vld[i]      = 1'b1;
    p_req[i].addr = a;
    p_req[i].data = d;
  endtask

  // Called at a falling edge: drive inputs, check ready, advance the model across the next rising edge.
  task automatic step();
    int w;
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]            = p_vld[i];
      bus.req_addr[i*AW +: AW]    = p_req[i].addr;
      bus.req_data[i*DW +: DW]    = p_req[i].data;
    end
`ifdef REGARB_SCOREBOARD_EN
    bus.rsv_valid = rsv_v;
    bus.rsv_addr  = rsv_a;
`endif
    #1;
    w = -1;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && p_vld[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    exp_ready = (w >= 0) ? N'(1) << w : '0;
    last_ready = bus.req_ready;
    chk("req_ready", bus.req_ready, exp_ready);
    for (int r = 0; r < REG_COUNT; r++) begin
      if (reset) m_busy[r] = 1'b0;
      else if (rsv_v && rsv_a == AW'(r) && r != 0) m_busy[r] = 1'b1;
      else if (exp_we && exp_addr == AW'(r)) m_busy[r] = 1'b0;
    end
    last_g = w;
    if (reset) begin
      exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_gid = 0; m_ptr = 0;
    end else if (w >= 0) begin
      exp_we   = (p_req[w].addr != AW'(REG_ZERO));
      exp_addr = p_req[w].addr;
      exp_data = p_req[w].data;
      exp_gid  = w;
      m_ptr    = (w + 1) % N;
      p_vld[w] = 1'b0;
    end else begin
      exp_we = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) p_vld[i] = 1'b0;
  endtask

  // Single compare process for the registered outputs.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("RegWrite", bus.RegWrite, exp_we);
      chk("WriteRegister", bus.WriteRegister, exp_addr);
      chk("WriteData", bus.WriteData, exp_data);
      chk("grant_id", bus.grant_id, exp_gid);
`ifdef REGARB_SCOREBOARD_EN
      chk("busy", bus.busy, m_busy);
`endif
    end
  end

  initial begin
    reset = 1'b1;
    rsv_v = 1'b0; rsv_a = '0;
    m_ptr = 0; exp_we = 0; exp_addr = '0; exp_data = '0; exp_gid = 0; m_busy = '0;
    for (int i = 0; i < N; i++) begin p_vld[i] = 1'b0; p_req[i] = '0; end
    @(negedge clk);
    step(); step();
    cmp_en = 1'b1;
    reset = 1'b0;
    chk("rst_RegWrite", bus.RegWrite, 1'b0);
    chk("rst_WriteRegister", bus.WriteRegister, 0);
    chk("rst_grant_id", bus.grant_id, 0);

    // Single request.
    pend(0, 5'd8, 32'h5);
    step();
    chk("t1_ready", last_ready, 3'b001);
    chk("t1_we", bus.RegWrite, 1'b1);
    chk("t1_addr", bus.WriteRegister, 8);
    chk("t1_data", bus.WriteData, 32'h5);
    chk("t1_gid", bus.grant_id, 0);
    step();
    chk("t1_we_drop", bus.RegWrite, 1'b0);

    // All three continuously valid from a fresh pointer.
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) if (!p_vld[i]) pend(i, AW'(i + 1), $urandom);
      step();
      chk("t2_grant", last_g, k % 3);
      chk("t2_we", bus.RegWrite, 1'b1);
    end
    clear_reqs();
    reset = 1'b1; step(); reset = 1'b0;

    // Pointer rotation after granting req1.
    pend(1, 5'd4, 32'h11); step();
    chk("t3_first", last_g, 1);
    pend(0, 5'd5, 32'h22); pend(2, 5'd6, 32'h33); step();
    chk("t3_second", last_g, 2);
    step();
    chk("t3_third", last_g, 0);

    // Zero register write from req2 (pointer now at 1).
    pend(2, 5'd0, 32'hDEADBEEF); step();
    chk("t4_ready", last_ready, 3'b100);
    chk("t4_we", bus.RegWrite, 1'b0);
    chk("t4_data", bus.WriteData, 32'hDEADBEEF);
    pend(0, 5'd7, 32'h44); pend(1, 5'd9, 32'h55); step();
    chk("t4_ptr_wrap", last_g, 0);
    step();

    // Reset the cycle after req1 is accepted.
    pend(1, 5'd5, 32'h66); step();
    chk("t5_accept", last_g, 1);
    pend(1, 5'd6, 32'h77);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t5_ready_in_rst", last_ready, 3'b000);
    chk("t5_we_after_rst", bus.RegWrite, 1'b0);
    step();
    chk("t5_regrant", last_g, 1);
    chk("t5_addr", bus.WriteRegister, 6);

`ifdef REGARB_SCOREBOARD_EN
    rsv_v = 1'b1; rsv_a = 5'd9; step(); rsv_v = 1'b0;
    chk("sb_set", bus.busy[9], 1'b1);
    pend(0, 5'd9, 32'h99); step();
    chk("sb_hold", bus.busy[9], 1'b1);
    step();
    chk("sb_clear", bus.busy[9], 1'b0);
    rsv_v = 1'b1; rsv_a = 5'd9; step(); rsv_v = 1'b0;
    pend(0, 5'd9, 32'h9A); step();
    rsv_v = 1'b1; rsv_a = 5'd9; step(); rsv_v = 1'b0;
    chk("sb_set_wins", bus.busy[9], 1'b1);
`endif

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 99) < 3);
      for (int i = 0; i < N; i++) begin
        if (!p_vld[i] && $urandom_range(0, 9) < 5)
          pend(i, ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom), $urandom);
      end
      rsv_v = ($urandom_range(0, 9) < 3);
      rsv_a = AW'($urandom);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
